// File: rtl/in_service_control_if.sv
// ----------------------------------------------------------------------------
// in_service_control_if : resolver/CPU-side signal bundle for the INTA/ISR stage
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface in_service_control_if;
  logic [7:0] interrupt;
  logic       ack_pulse;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       rotate_on_aeoi;
  logic       eoi_strobe;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       set_priority_strobe;

  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] clear_interrupt_request;
  logic       interrupt_to_cpu;
  logic [7:0] vector_out;
  logic       vector_valid;

  modport master (
    output interrupt, ack_pulse, vector_base, auto_eoi, rotate_on_aeoi,
           eoi_strobe, eoi_specific, eoi_rotate, eoi_level, set_priority_strobe,
    input  in_service_register, priority_rotate, clear_interrupt_request,
           interrupt_to_cpu, vector_out, vector_valid
  );

  modport slave (
    input  interrupt, ack_pulse, vector_base, auto_eoi, rotate_on_aeoi,
           eoi_strobe, eoi_specific, eoi_rotate, eoi_level, set_priority_strobe,
    output in_service_register, priority_rotate, clear_interrupt_request,
           interrupt_to_cpu, vector_out, vector_valid
  );
endinterface

`default_nettype wire

// File: rtl/in_service_control.sv
// ----------------------------------------------------------------------------
// in_service_control : INTA acknowledge sequencing, ISR, EOI and priority rotation
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module in_service_control (
  input  logic                       clk,
  input  logic                       reset,
  in_service_control_if.slave        bus
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_ACK2 = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic [7:0] clr_req_q, clr_req_d;
  logic [7:0] vec_q, vec_d;
  logic       vvalid_q, vvalid_d;

  logic       irq_any;
  logic [2:0] irq_level;
  logic       ns_found;
  logic [2:0] ns_level;
  logic [2:0] ns_idx;

  logic [7:0] isr_set;
  logic [7:0] aeoi_clr;
  logic       aeoi_rot;
  logic [7:0] cmd_clr;
  logic       eoi_rot;
  logic [2:0] eoi_rot_level;

  // The resolver winner is one-hot; lowest index wins should it ever not be.
  always_comb begin
    irq_any   = |bus.interrupt;
    irq_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.interrupt[i]) begin
        irq_level = 3'(i);
      end
    end
  end

  // Non-specific EOI search starts just above the lowest-priority level and wraps.
  always_comb begin
    ns_found = 1'b0;
    ns_level = 3'd0;
    ns_idx   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      ns_idx = rot_q + 3'(i);
      if (!ns_found && isr_q[ns_idx]) begin
        ns_found = 1'b1;
        ns_level = ns_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    clr_req_d  = 8'd0;
    vec_d      = vec_q;
    vvalid_d   = 1'b0;
    isr_set    = 8'd0;
    aeoi_clr   = 8'd0;
    aeoi_rot   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ack_pulse) begin
          state_d    = WAIT_ACK2;
          spurious_d = !irq_any;
          if (irq_any) begin
            level_d   = irq_level;
            isr_set   = 8'd1 << irq_level;
            clr_req_d = 8'd1 << irq_level;
          end else begin
            level_d = 3'd7;
          end
        end
      end
      WAIT_ACK2: begin
        if (bus.ack_pulse) begin
          state_d  = IDLE;
          vec_d    = {bus.vector_base, level_q};
          vvalid_d = 1'b1;
          if (bus.auto_eoi && !spurious_q) begin
            aeoi_clr = 8'd1 << level_q;
            aeoi_rot = bus.rotate_on_aeoi;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_clr       = 8'd0;
    eoi_rot       = 1'b0;
    eoi_rot_level = 3'd0;
    if (bus.eoi_strobe) begin
      if (bus.eoi_specific) begin
        cmd_clr       = 8'd1 << bus.eoi_level;
        eoi_rot       = bus.eoi_rotate;
        eoi_rot_level = bus.eoi_level;
      end else if (ns_found) begin
        cmd_clr       = 8'd1 << ns_level;
        eoi_rot       = bus.eoi_rotate;
        eoi_rot_level = ns_level;
      end
    end

    // A set in the same cycle as a clear of the same bit keeps the bit set.
    isr_d = (isr_q & ~(aeoi_clr | cmd_clr)) | isr_set;

    if (bus.set_priority_strobe) begin
      rot_d = bus.eoi_level;
    end else if (eoi_rot) begin
      rot_d = eoi_rot_level;
    end else if (aeoi_rot) begin
      rot_d = level_q;
    end else begin
      rot_d = rot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      level_q    <= 3'd0;
      spurious_q <= 1'b0;
      isr_q      <= 8'd0;
      rot_q      <= 3'd7;
      clr_req_q  <= 8'd0;
      vec_q      <= 8'd0;
      vvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      spurious_q <= spurious_d;
      isr_q      <= isr_d;
      rot_q      <= rot_d;
      clr_req_q  <= clr_req_d;
      vec_q      <= vec_d;
      vvalid_q   <= vvalid_d;
    end
  end

  assign bus.in_service_register     = isr_q;
  assign bus.priority_rotate         = rot_q;
  assign bus.clear_interrupt_request = clr_req_q;
  assign bus.vector_out              = vec_q;
  assign bus.vector_valid            = vvalid_q;
  assign bus.interrupt_to_cpu        = (state_q == IDLE) && irq_any;

endmodule

`default_nettype wire

// File: tb/tb_in_service_control.sv
// ----------------------------------------------------------------------------
// tb_in_service_control : directed self-checking bench for in_service_control
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_in_service_control;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  in_service_control_if bus ();

  in_service_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_once(input logic [7:0] irq);
    bus.interrupt = irq;
    bus.ack_pulse = 1'b1;
    tick();
    bus.ack_pulse = 1'b0;
  endtask

  task automatic ack_pair(input logic [7:0] irq);
    ack_once(irq);
    tick();
    ack_once(irq);
    bus.interrupt = 8'h00;
  endtask

  task automatic eoi_cmd(input logic spec, input logic rot, input logic [2:0] lvl);
    bus.eoi_strobe   = 1'b1;
    bus.eoi_specific = spec;
    bus.eoi_rotate   = rot;
    bus.eoi_level    = lvl;
    tick();
    bus.eoi_strobe   = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_rotate   = 1'b0;
  endtask

  task automatic set_prio(input logic [2:0] lvl);
    bus.set_priority_strobe = 1'b1;
    bus.eoi_level           = lvl;
    tick();
    bus.set_priority_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.in_service_register !== 8'h00) begin
      failures++;
      $display("FAIL reset_isr got=%h exp=%h", bus.in_service_register, 8'h00);
    end
    checks++;
    if (bus.priority_rotate !== 3'd7) begin
      failures++;
      $display("FAIL reset_rot got=%0d exp=%0d", bus.priority_rotate, 7);
    end
    checks++;
    if ({bus.clear_interrupt_request, bus.vector_out, bus.vector_valid, bus.interrupt_to_cpu} !== 18'd0) begin
      failures++;
      $display("FAIL reset_outs clr=%h vec=%h vv=%b int=%b exp all zero",
               bus.clear_interrupt_request, bus.vector_out, bus.vector_valid, bus.interrupt_to_cpu);
    end
  endtask

  task automatic test_basic_ack();
    bus.vector_base = 5'h11;
    bus.interrupt   = 8'h08;
    #1;
    checks++;
    if (bus.interrupt_to_cpu !== 1'b1) begin
      failures++;
      $display("FAIL basic_int_high got=%b exp=1", bus.interrupt_to_cpu);
    end
    ack_once(8'h08);
    checks++;
    if (bus.in_service_register !== 8'h08) begin
      failures++;
      $display("FAIL basic_isr got=%h exp=%h", bus.in_service_register, 8'h08);
    end
    checks++;
    if (bus.clear_interrupt_request !== 8'h08) begin
      failures++;
      $display("FAIL basic_clr got=%h exp=%h", bus.clear_interrupt_request, 8'h08);
    end
    checks++;
    if (bus.interrupt_to_cpu !== 1'b0) begin
      failures++;
      $display("FAIL basic_int_low got=%b exp=0", bus.interrupt_to_cpu);
    end
    tick();
    checks++;
    if (bus.clear_interrupt_request !== 8'h00) begin
      failures++;
      $display("FAIL basic_clr_pulse got=%h exp=%h", bus.clear_interrupt_request, 8'h00);
    end
    ack_once(8'h08);
    bus.interrupt = 8'h00;
    checks++;
    if (bus.vector_out !== 8'h8B || bus.vector_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_vector got=%h/%b exp=8b/1", bus.vector_out, bus.vector_valid);
    end
    tick();
    checks++;
    if (bus.vector_out !== 8'h8B || bus.vector_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_vector_hold got=%h/%b exp=8b/0", bus.vector_out, bus.vector_valid);
    end
    eoi_cmd(1'b1, 1'b0, 3'd3);
    checks++;
    if (bus.in_service_register !== 8'h00) begin
      failures++;
      $display("FAIL specific_eoi got=%h exp=%h", bus.in_service_register, 8'h00);
    end
  endtask

  task automatic test_nseoi_rotate();
    ack_pair(8'h04);
    ack_pair(8'h20);
    checks++;
    if (bus.in_service_register !== 8'h24) begin
      failures++;
      $display("FAIL nseoi_setup got=%h exp=%h", bus.in_service_register, 8'h24);
    end
    eoi_cmd(1'b0, 1'b1, 3'd0);
    checks++;
    if (bus.in_service_register !== 8'h20 || bus.priority_rotate !== 3'd2) begin
      failures++;
      $display("FAIL nseoi_rotate got=%h/%0d exp=20/2", bus.in_service_register, bus.priority_rotate);
    end
  endtask

  task automatic test_wrap_search();
    set_prio(3'd5);
    eoi_cmd(1'b1, 1'b0, 3'd5);
    ack_pair(8'h40);
    ack_pair(8'h01);
    checks++;
    if (bus.in_service_register !== 8'h41 || bus.priority_rotate !== 3'd5) begin
      failures++;
      $display("FAIL wrap_setup got=%h/%0d exp=41/5", bus.in_service_register, bus.priority_rotate);
    end
    eoi_cmd(1'b0, 1'b0, 3'd0);
    checks++;
    if (bus.in_service_register !== 8'h01 || bus.priority_rotate !== 3'd5) begin
      failures++;
      $display("FAIL wrap_search got=%h/%0d exp=01/5", bus.in_service_register, bus.priority_rotate);
    end
    eoi_cmd(1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_aeoi_rotate();
    bus.auto_eoi       = 1'b1;
    bus.rotate_on_aeoi = 1'b1;
    ack_once(8'h02);
    checks++;
    if (bus.in_service_register !== 8'h02) begin
      failures++;
      $display("FAIL aeoi_first got=%h exp=%h", bus.in_service_register, 8'h02);
    end
    ack_once(8'h02);
    bus.interrupt = 8'h00;
    checks++;
    if (bus.in_service_register !== 8'h00 || bus.priority_rotate !== 3'd1 || bus.vector_out !== 8'h89) begin
      failures++;
      $display("FAIL aeoi_second got=%h/%0d/%h exp=00/1/89",
               bus.in_service_register, bus.priority_rotate, bus.vector_out);
    end
    bus.auto_eoi       = 1'b0;
    bus.rotate_on_aeoi = 1'b0;
  endtask

  task automatic test_spurious();
    ack_pair(8'h10);
    ack_once(8'h00);
    checks++;
    if (bus.in_service_register !== 8'h10 || bus.clear_interrupt_request !== 8'h00) begin
      failures++;
      $display("FAIL spurious_first got=%h/%h exp=10/00", bus.in_service_register, bus.clear_interrupt_request);
    end
    ack_once(8'h00);
    checks++;
    if (bus.vector_out !== 8'h8F || bus.vector_valid !== 1'b1 || bus.in_service_register !== 8'h10) begin
      failures++;
      $display("FAIL spurious_vector got=%h/%b/%h exp=8f/1/10",
               bus.vector_out, bus.vector_valid, bus.in_service_register);
    end
    eoi_cmd(1'b1, 1'b0, 3'd4);
  endtask

  task automatic test_back_to_back();
    bus.interrupt = 8'h01;
    bus.ack_pulse = 1'b1;
    tick();
    checks++;
    if (bus.in_service_register !== 8'h01 || bus.clear_interrupt_request !== 8'h01) begin
      failures++;
      $display("FAIL b2b_first got=%h/%h exp=01/01", bus.in_service_register, bus.clear_interrupt_request);
    end
    tick();
    bus.ack_pulse = 1'b0;
    bus.interrupt = 8'h00;
    checks++;
    if (bus.vector_out !== 8'h88 || bus.vector_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_vector got=%h/%b exp=88/1", bus.vector_out, bus.vector_valid);
    end
    // Set-priority outranks EOI rotation in the same cycle.
    bus.set_priority_strobe = 1'b1;
    eoi_cmd(1'b0, 1'b1, 3'd6);
    bus.set_priority_strobe = 1'b0;
    checks++;
    if (bus.in_service_register !== 8'h00 || bus.priority_rotate !== 3'd6) begin
      failures++;
      $display("FAIL rot_precedence got=%h/%0d exp=00/6", bus.in_service_register, bus.priority_rotate);
    end
  endtask

  task automatic test_collision_reset();
    bus.interrupt    = 8'h08;
    bus.ack_pulse    = 1'b1;
    bus.eoi_strobe   = 1'b1;
    bus.eoi_specific = 1'b1;
    bus.eoi_level    = 3'd3;
    tick();
    bus.ack_pulse    = 1'b0;
    bus.eoi_strobe   = 1'b0;
    bus.eoi_specific = 1'b0;
    checks++;
    if (bus.in_service_register !== 8'h08) begin
      failures++;
      $display("FAIL collision_isr got=%h exp=%h", bus.in_service_register, 8'h08);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.in_service_register !== 8'h00 || bus.priority_rotate !== 3'd7 ||
        bus.clear_interrupt_request !== 8'h00 || bus.vector_out !== 8'h00 || bus.vector_valid !== 1'b0) begin
      failures++;
      $display("FAIL midseq_reset got isr=%h rot=%0d clr=%h vec=%h vv=%b exp 00/7/00/00/0",
               bus.in_service_register, bus.priority_rotate, bus.clear_interrupt_request,
               bus.vector_out, bus.vector_valid);
    end
    checks++;
    if (bus.interrupt_to_cpu !== 1'b1) begin
      failures++;
      $display("FAIL midseq_reset_idle got=%b exp=1", bus.interrupt_to_cpu);
    end
    ack_once(8'h08);
    checks++;
    if (bus.clear_interrupt_request !== 8'h08) begin
      failures++;
      $display("FAIL post_reset_ack got=%h exp=%h", bus.clear_interrupt_request, 8'h08);
    end
  endtask

  initial begin
    checks                  = 0;
    failures                = 0;
    reset                   = 1'b1;
    bus.interrupt           = 8'h00;
    bus.ack_pulse           = 1'b0;
    bus.vector_base         = 5'h11;
    bus.auto_eoi            = 1'b0;
    bus.rotate_on_aeoi      = 1'b0;
    bus.eoi_strobe          = 1'b0;
    bus.eoi_specific        = 1'b0;
    bus.eoi_rotate          = 1'b0;
    bus.eoi_level           = 3'd0;
    bus.set_priority_strobe = 1'b0;

    test_reset();
    test_basic_ack();
    test_nseoi_rotate();
    test_wrap_search();
    test_aeoi_rotate();
    test_spurious();
    test_back_to_back();
    test_collision_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/in_service_control.md
# in_service_control

Interrupt acknowledge and in-service bookkeeping stage of the PIC, directly downstream of the priority resolver. Consumes the resolver's one-hot `interrupt` output, runs the two-pulse INTA acknowledge sequence, and owns the in-service register (ISR) and the rotation pointer `priority_rotate`, both of which feed back into the resolver. Also handles end-of-interrupt (EOI) commands, automatic EOI and priority rotation, and presents the 8-bit vector to the data-bus buffer.

## Interface
- No parameters; width fixed at 8 levels.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `interrupt` in 8: one-hot or zero winner from the priority resolver.
- `ack_pulse` in 1: one-cycle strobe per INTA cycle, already edge-detected upstream.
- `vector_base` in 5: vector bits T7..T3 from ICW2.
- `auto_eoi` in 1: AEOI mode.
- `rotate_on_aeoi` in 1: rotate on automatic EOI.
- `eoi_strobe` in 1: one-cycle OCW2 EOI command.
- `eoi_specific` in 1: 1 selects a specific EOI, 0 a non-specific EOI.
- `eoi_rotate` in 1: rotate on this EOI.
- `eoi_level` in 3: target level for a specific EOI.
- `set_priority_strobe` in 1: one-cycle OCW2 set-priority command; uses `eoi_level`.
- `in_service_register` out 8: ISR, to the resolver.
- `priority_rotate` out 3: lowest-priority level, to the resolver; 7 means fixed priority with IR0 highest.
- `clear_interrupt_request` out 8: one-cycle one-hot pulse that clears the IRR bit.
- `interrupt_to_cpu` out 1: INT pin.
- `vector_out` out 8: {`vector_base`, level}.
- `vector_valid` out 1: one-cycle strobe that qualifies `vector_out`.

## Operation
- **States:** IDLE and WAIT_ACK2.
- **IDLE:**
  - `interrupt_to_cpu` = |`interrupt` (combinational, gated by state).
  - On `ack_pulse`, capture `level` = encode(`interrupt`).
  - If `interrupt` == 0, the request is spurious: `level` = 7, no ISR set, no IRR clear.
  - Otherwise, set ISR[level] and pulse `clear_interrupt_request`[level].
  - Go to WAIT_ACK2.
- **WAIT_ACK2:**
  - `interrupt_to_cpu` = 0.
  - On `ack_pulse`, drive `vector_out` = {`vector_base`, `level`} and `vector_valid` = 1, then return to IDLE.
  - If `auto_eoi` is set and the request was not spurious, clear ISR[level].
  - If `rotate_on_aeoi` is also set, `priority_rotate` <= `level`.
- **Non-specific EOI:**
  - Clears the highest-priority set ISR bit.
  - Search order is `priority_rotate`+1, +2, … mod 8 (wrap-around).
  - If `eoi_rotate` is set, `priority_rotate` <= the cleared level.
  - If ISR is 0, nothing changes and no rotation occurs.
- **Specific EOI:**
  - Clears ISR[`eoi_level`], even if the bit is already 0.
  - If `eoi_rotate` is set, `priority_rotate` <= `eoi_level` unconditionally.
- **Set priority:** `priority_rotate` <= `eoi_level`; ISR is unchanged.
- **ISR update:** ISR_next = (ISR & ~clr) | set. Set wins when the same bit is both set and cleared; clr is the OR of the AEOI and command clears.
- **Rotation precedence, same cycle:** set-priority, then EOI rotate, then AEOI rotate.
- **Reset:**
  - ISR = 0, `priority_rotate` = 7, state = IDLE, `level` = 0.
  - `clear_interrupt_request` = 0, `vector_out` = 0, `vector_valid` = 0.
  - Reset has the same effect mid-sequence, including in WAIT_ACK2.

## Timing
- All outputs are registered except `interrupt_to_cpu`.
- First `ack_pulse` in cycle N:
  - ISR bit visible in N+1.
  - `clear_interrupt_request` high for N+1 only.
  - `interrupt_to_cpu` low from N+1.
- Second `ack_pulse` in cycle M: `vector_out`/`vector_valid` in M+1; `vector_valid` is high for exactly one cycle, and `vector_out` holds until the next vector.
- AEOI ISR clear and rotation become visible in M+1.
- EOI and set-priority strobes in cycle K take effect in K+1.
- ISR feedback to the resolver therefore lags one cycle. The resolver output sampled in the `ack_pulse` cycle is authoritative.
- Back-to-back `ack_pulse` in consecutive cycles is legal. A third `ack_pulse` arriving in IDLE starts a new sequence.

## Test plan
- **Basic acknowledge, fixed priority:**
  - Stimulus: reset, `interrupt`=0x08, `vector_base`=5'h11, two `ack_pulse`s.
  - Required: ISR=0x08; `clear_interrupt_request`=0x08 for one cycle; `vector_out`=0x8B with `vector_valid` pulse; INT low between the acks.
- **Non-specific EOI with rotation:**
  - Stimulus: ISR=0x24 (via two acks), `priority_rotate`=7, then `eoi_strobe` with non-specific EOI and `eoi_rotate`=1.
  - Required: ISR=0x20, `priority_rotate`=2.
- **Wrap-around search:**
  - Stimulus: `priority_rotate`=5, ISR=0x41, then non-specific EOI.
  - Required: clears bit 6 (level 6 precedes level 0 in the search), leaving ISR=0x01.
- **AEOI with rotate:**
  - Stimulus: `auto_eoi`=1, `rotate_on_aeoi`=1, `interrupt`=0x02, two acks.
  - Required: ISR=0x02 after the first ack, ISR=0x00 after the second; `priority_rotate`=1.
- **Spurious acknowledge:**
  - Stimulus: `interrupt`=0 at the first ack, then the second ack.
  - Required: ISR unchanged; `clear_interrupt_request`=0; `vector_out`={base, 3'd7}.
- **Collision and reset:**
  - Stimulus: same-cycle first ack on level 3 plus specific EOI level 3; then reset asserted in WAIT_ACK2.
  - Required: ISR[3]=1 after the collision; after reset, all outputs at their reset values and state IDLE.
